// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the serial convolution window sequencer.
package conv_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_OUT,
      S_DONE
   } conv_state_t;

   function automatic int acc_width(input int dw, input int kw, input int k);
      return dw + kw + $clog2(k * k);
   endfunction

   function automatic int out_dim(input int img, input int k);
      return img - k + 1;
   endfunction

   // Counter/address width that never collapses to zero bits.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate with clear-on-first-tap; owns the accumulator register.
module conv_mac
#(
   parameter int DATA_WIDTH  = 8,
   parameter int KDATA_WIDTH = 8,
   parameter int ACC_WIDTH   = 18
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_en,
   input  logic                          i_clr,
   input  logic signed [DATA_WIDTH-1:0]  i_pix,
   input  logic signed [KDATA_WIDTH-1:0] i_coef,
   output logic signed [ACC_WIDTH-1:0]   o_acc_next
);

   logic signed [ACC_WIDTH-1:0]              r_acc;
   logic signed [DATA_WIDTH+KDATA_WIDTH-1:0] w_prod;
   logic signed [ACC_WIDTH-1:0]              w_base;

   always_comb begin
      w_prod     = i_pix * i_coef;
      w_base     = i_clr ? '0 : r_acc;
      // Exposed combinationally so the final tap can be registered straight into the output stage.
      o_acc_next = i_en ? (w_base + ACC_WIDTH'(w_prod)) : r_acc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_acc <= '0;
      else if (i_en)
         r_acc <= o_acc_next;
   end

endmodule

// File: rtl/conv_window_ctrl.sv
// Serial stride-1, no-padding 2-D convolution sequencer: one MAC per cycle, valid/ready result port.
module conv_window_ctrl
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int KDATA_WIDTH = 8,
   parameter int KERNEL_SIZE = 2,
   parameter int IMGROW      = 7,
   parameter int IMGCOL      = 3,
   parameter     ACTIVATION  = "RELU"
)(
   input  logic                                                         clk,
   input  logic                                                         rst,
   input  logic                                                         start,
   input  logic [KERNEL_SIZE*KERNEL_SIZE*KDATA_WIDTH-1:0]               kernel_flat,
   output logic                                                         busy,
   output logic                                                         done,
   output logic                                                         img_rd_en,
   output logic [cnt_width(IMGROW)-1:0]                                 img_rd_row,
   output logic [cnt_width(IMGCOL)-1:0]                                 img_rd_col,
   input  logic signed [DATA_WIDTH-1:0]                                 img_rd_data,
   output logic                                                         out_valid,
   input  logic                                                         out_ready,
   output logic signed [acc_width(DATA_WIDTH,KDATA_WIDTH,KERNEL_SIZE)-1:0] out_data,
   output logic [cnt_width(out_dim(IMGROW,KERNEL_SIZE))-1:0]            out_row,
   output logic [cnt_width(out_dim(IMGCOL,KERNEL_SIZE))-1:0]            out_col
);

   localparam int K      = KERNEL_SIZE;
   localparam int NTAP   = K * K;
   localparam int ACC_W  = acc_width(DATA_WIDTH, KDATA_WIDTH, K);
   localparam int OUTROW = out_dim(IMGROW, K);
   localparam int OUTCOL = out_dim(IMGCOL, K);
   localparam int RW     = cnt_width(IMGROW);
   localparam int CW     = cnt_width(IMGCOL);
   localparam int ORW    = cnt_width(OUTROW);
   localparam int OCW    = cnt_width(OUTCOL);
   localparam int KW     = cnt_width(K);
   localparam int TW     = cnt_width(NTAP);

   localparam logic [ORW-1:0] LAST_WR  = ORW'(OUTROW - 1);
   localparam logic [OCW-1:0] LAST_WC  = OCW'(OUTCOL - 1);
   localparam logic [KW-1:0]  LAST_K   = KW'(K - 1);
   localparam bit             USE_RELU = (ACTIVATION == "RELU");

   conv_state_t                    r_state;
   logic [ORW-1:0]                 r_wr;
   logic [OCW-1:0]                 r_wc;
   logic [KW-1:0]                  r_kr;
   logic [KW-1:0]                  r_kc;
   logic [TW-1:0]                  r_tap;
   logic signed [KDATA_WIDTH-1:0]  r_kernel [NTAP];
   logic                           r_mac_en;
   logic                           r_mac_clr;
   logic [TW-1:0]                  r_mac_tap;

   logic [KW-1:0]                  w_kr_nxt;
   logic [KW-1:0]                  w_kc_nxt;
   logic [ORW-1:0]                 w_wr_nxt;
   logic [OCW-1:0]                 w_wc_nxt;
   logic                           w_last_tap;
   logic                           w_last_win;
   logic signed [ACC_W-1:0]        w_acc_next;
   logic signed [ACC_W-1:0]        w_act;

   always_comb begin
      w_kc_nxt   = (r_kc == LAST_K) ? '0 : r_kc + 1'b1;
      w_kr_nxt   = (r_kc == LAST_K) ? r_kr + 1'b1 : r_kr;
      w_wc_nxt   = (r_wc == LAST_WC) ? '0 : r_wc + 1'b1;
      w_wr_nxt   = (r_wc == LAST_WC) ? r_wr + 1'b1 : r_wr;
      w_last_tap = (r_kr == LAST_K) && (r_kc == LAST_K);
      w_last_win = (r_wr == LAST_WR) && (r_wc == LAST_WC);
      w_act      = (USE_RELU && w_acc_next[ACC_W-1]) ? '0 : w_acc_next;
   end

   // Read data lands one cycle after the strobe, so the MAC controls trail the issued tap by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mac_en  <= 1'b0;
         r_mac_clr <= 1'b0;
         r_mac_tap <= '0;
      end else begin
         r_mac_en  <= img_rd_en;
         r_mac_clr <= img_rd_en && (r_tap == '0);
         r_mac_tap <= r_tap;
      end
   end

   conv_mac #(
      .DATA_WIDTH  (DATA_WIDTH),
      .KDATA_WIDTH (KDATA_WIDTH),
      .ACC_WIDTH   (ACC_W)
   ) u_mac (
      .clk        (clk),
      .rst        (rst),
      .i_en       (r_mac_en),
      .i_clr      (r_mac_clr),
      .i_pix      (img_rd_data),
      .i_coef     (r_kernel[r_mac_tap]),
      .o_acc_next (w_acc_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         img_rd_en  <= 1'b0;
         img_rd_row <= '0;
         img_rd_col <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_row    <= '0;
         out_col    <= '0;
         r_wr       <= '0;
         r_wc       <= '0;
         r_kr       <= '0;
         r_kc       <= '0;
         r_tap      <= '0;
         for (int unsigned i = 0; i < NTAP; i++) r_kernel[i] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  for (int unsigned i = 0; i < NTAP; i++)
                     r_kernel[i] <= kernel_flat[i*KDATA_WIDTH +: KDATA_WIDTH];
                  r_wr       <= '0;
                  r_wc       <= '0;
                  r_kr       <= '0;
                  r_kc       <= '0;
                  r_tap      <= '0;
                  img_rd_en  <= 1'b1;
                  img_rd_row <= '0;
                  img_rd_col <= '0;
                  busy       <= 1'b1;
                  r_state    <= S_READ;
               end
            end
            S_READ: begin
               if (w_last_tap) begin
                  img_rd_en <= 1'b0;
                  r_state   <= S_DRAIN;
               end else begin
                  r_kr       <= w_kr_nxt;
                  r_kc       <= w_kc_nxt;
                  r_tap      <= r_tap + 1'b1;
                  img_rd_row <= RW'(r_wr) + RW'(w_kr_nxt);
                  img_rd_col <= CW'(r_wc) + CW'(w_kc_nxt);
               end
            end
            S_DRAIN: begin
               out_valid <= 1'b1;
               out_data  <= w_act;
               out_row   <= r_wr;
               out_col   <= r_wc;
               r_state   <= S_OUT;
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (w_last_win) begin
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     r_state <= S_DONE;
                  end else begin
                     r_wr       <= w_wr_nxt;
                     r_wc       <= w_wc_nxt;
                     r_kr       <= '0;
                     r_kc       <= '0;
                     r_tap      <= '0;
                     img_rd_en  <= 1'b1;
                     img_rd_row <= RW'(w_wr_nxt);
                     img_rd_col <= CW'(w_wc_nxt);
                     r_state    <= S_READ;
                  end
               end
            end
            S_DONE: begin
               done    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Randomized self-checking bench: RELU and NONE instances checked against a direct convolution model.
module tb_conv_window_ctrl;

   localparam int DW = 8;
   localparam int KW = 8;
   localparam int K  = 2;
   localparam int IR = 7;
   localparam int IC = 3;
   localparam int OR = IR - K + 1;
   localparam int OC = IC - K + 1;
   localparam int AW = DW + KW + $clog2(K * K);

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic [K*K*KW-1:0] kernel_flat;
   logic out_ready;

   logic                 a_busy, a_done, a_rd_en, a_out_valid;
   logic [2:0]           a_rd_row;
   logic [1:0]           a_rd_col;
   logic signed [DW-1:0] a_rd_data;
   logic signed [AW-1:0] a_out_data;
   logic [2:0]           a_out_row;
   logic [0:0]           a_out_col;

   logic                 b_busy, b_done, b_rd_en, b_out_valid;
   logic [2:0]           b_rd_row;
   logic [1:0]           b_rd_col;
   logic signed [DW-1:0] b_rd_data;
   logic signed [AW-1:0] b_out_data;
   logic [2:0]           b_out_row;
   logic [0:0]           b_out_col;

   always #5 clk = ~clk;

   conv_window_ctrl #(
      .DATA_WIDTH(DW), .KDATA_WIDTH(KW), .KERNEL_SIZE(K),
      .IMGROW(IR), .IMGCOL(IC), .ACTIVATION("RELU")
   ) u_dut (
      .clk(clk), .rst(rst), .start(start), .kernel_flat(kernel_flat),
      .busy(a_busy), .done(a_done), .img_rd_en(a_rd_en),
      .img_rd_row(a_rd_row), .img_rd_col(a_rd_col), .img_rd_data(a_rd_data),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
      .out_row(a_out_row), .out_col(a_out_col)
   );

   conv_window_ctrl #(
      .DATA_WIDTH(DW), .KDATA_WIDTH(KW), .KERNEL_SIZE(K),
      .IMGROW(IR), .IMGCOL(IC), .ACTIVATION("NONE")
   ) u_dut_none (
      .clk(clk), .rst(rst), .start(start), .kernel_flat(kernel_flat),
      .busy(b_busy), .done(b_done), .img_rd_en(b_rd_en),
      .img_rd_row(b_rd_row), .img_rd_col(b_rd_col), .img_rd_data(b_rd_data),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
      .out_row(b_out_row), .out_col(b_out_col)
   );

   int img [IR][IC];
   int kern [K*K];
   int res_relu [OR][OC];
   int res_none [OR][OC];

   typedef struct { int r; int c; } addr_t;
   typedef struct { int r; int c; int raw; } exp_t;
   addr_t q_addr [$];
   exp_t  q_exp  [$];

   int n_checks = 0;
   int n_fail   = 0;
   int n_hs     = 0;
   int n_done   = 0;
   int n_busy   = 0;

   task automatic check_eq(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Synchronous image memories, one per instance.
   always @(posedge clk) begin
      if (a_rd_en)
         a_rd_data <= (int'(a_rd_row) < IR && int'(a_rd_col) < IC) ? DW'(img[a_rd_row][a_rd_col]) : '0;
      if (b_rd_en)
         b_rd_data <= (int'(b_rd_row) < IR && int'(b_rd_col) < IC) ? DW'(img[b_rd_row][b_rd_col]) : '0;
   end

   // Direct convolution: raster order of windows, taps column-fastest.
   task automatic build_model();
      int sum;
      q_addr.delete();
      q_exp.delete();
      for (int r = 0; r < OR; r++)
         for (int c = 0; c < OC; c++) begin
            sum = 0;
            for (int kr = 0; kr < K; kr++)
               for (int kc = 0; kc < K; kc++) begin
                  sum += img[r+kr][c+kc] * kern[kr*K+kc];
                  q_addr.push_back('{r + kr, c + kc});
               end
            q_exp.push_back('{r, c, sum});
         end
   endtask

   task automatic load_fixed();
      int rows [IR][IC];
      rows = '{'{-2,4,-1}, '{4,1,-1}, '{1,6,-1}, '{2,4,-1}, '{6,2,-1}, '{6,1,-1}, '{1,2,-1}};
      img  = rows;
      kern = '{2, -14, -4, -2};
   endtask

   task automatic load_random();
      for (int r = 0; r < IR; r++)
         for (int c = 0; c < IC; c++)
            img[r][c] = int'($urandom_range(0, 255)) - 128;
      for (int i = 0; i < K*K; i++)
         kern[i] = int'($urandom_range(0, 255)) - 128;
   endtask

   function automatic logic [K*K*KW-1:0] pack_kernel();
      logic [K*K*KW-1:0] f;
      f = '0;
      for (int i = 0; i < K*K; i++) f[i*KW +: KW] = KW'(kern[i]);
      return f;
   endfunction

   addr_t m_a;
   exp_t  m_e;
   logic  m_pv, m_pr;
   logic signed [AW-1:0] m_pd;
   logic [2:0] m_prow;
   logic [0:0] m_pcol;

   always @(negedge clk) begin
      if (rst) begin
         m_pv = 1'b0;
         m_pr = 1'b0;
      end else begin
         if (a_busy) n_busy++;
         if (a_done) n_done++;
         if (a_rd_en) begin
            check_eq("rd_in_range", longint'(int'(a_rd_row) < IR && int'(a_rd_col) < IC), 1);
            if (q_addr.size() == 0)
               check_eq("rd_unexpected", 1, 0);
            else begin
               m_a = q_addr.pop_front();
               check_eq("rd_row", a_rd_row, m_a.r);
               check_eq("rd_col", a_rd_col, m_a.c);
            end
         end
         if (m_pv && !m_pr) begin
            check_eq("hold_valid", a_out_valid, 1);
            check_eq("hold_data", a_out_data, m_pd);
            check_eq("hold_row", a_out_row, m_prow);
            check_eq("hold_col", a_out_col, m_pcol);
            check_eq("no_rd_in_out", a_rd_en, 0);
         end
         if (a_out_valid && out_ready) begin
            n_hs++;
            if (q_exp.size() == 0)
               check_eq("out_unexpected", 1, 0);
            else begin
               m_e = q_exp.pop_front();
               check_eq("out_row", a_out_row, m_e.r);
               check_eq("out_col", a_out_col, m_e.c);
               check_eq("out_relu", a_out_data, (m_e.raw < 0) ? 0 : m_e.raw);
               check_eq("none_valid", b_out_valid, 1);
               check_eq("out_none", b_out_data, m_e.raw);
               res_relu[m_e.r][m_e.c] = int'(a_out_data);
               res_none[m_e.r][m_e.c] = int'(b_out_data);
            end
         end
         m_pv   = a_out_valid;
         m_pr   = out_ready;
         m_pd   = a_out_data;
         m_prow = a_out_row;
         m_pcol = a_out_col;
      end
   end

   // mode 0: ready held high, 1: random ready, 2: five stall cycles per output.
   task automatic run_conv(input int mode, input bit spam);
      int hs0, dn0, bz0, cnt, stall;
      build_model();
      hs0 = n_hs; dn0 = n_done; bz0 = n_busy;
      kernel_flat = pack_kernel();
      out_ready   = (mode == 0);
      start       = 1'b1;
      @(posedge clk); #2;
      start       = spam;
      kernel_flat = $urandom;
      cnt = 0; stall = 0;
      while (n_done == dn0 && cnt < 3000) begin
         case (mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
               if (a_out_valid) begin
                  out_ready = (stall >= 5);
                  stall++;
               end else begin
                  out_ready = 1'b0;
                  stall = 0;
               end
            end
         endcase
         @(posedge clk); #2;
         cnt++;
      end
      start = 1'b0;
      check_eq("run_timeout", longint'(cnt < 3000), 1);
      check_eq("n_outputs", n_hs - hs0, OR * OC);
      check_eq("n_done", n_done - dn0, 1);
      check_eq("exp_left", q_exp.size(), 0);
      check_eq("addr_left", q_addr.size(), 0);
      if (mode == 0)
         check_eq("busy_cycles", n_busy - bz0, OR * OC * (K * K + 2));
      repeat (4) @(posedge clk);
      #2;
      check_eq("idle_busy", a_busy, 0);
      check_eq("no_extra_done", n_done - dn0, 1);
   endtask

   task automatic reset_mid_run();
      int hs0, dn0, cnt;
      build_model();
      hs0 = n_hs; dn0 = n_done;
      kernel_flat = pack_kernel();
      out_ready   = 1'b1;
      start       = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      cnt = 0;
      while (!((n_hs - hs0) >= 2 && a_rd_en) && cnt < 500) begin
         @(posedge clk); #2;
         cnt++;
      end
      check_eq("rst_reach_timeout", longint'(cnt < 500), 1);
      check_eq("rst_at_win_row", a_rd_row, 1);
      check_eq("rst_at_win_col", a_rd_col, 0);
      rst = 1'b1;
      #1;
      check_eq("mid_rst_busy", a_busy, 0);
      check_eq("mid_rst_done", a_done, 0);
      check_eq("mid_rst_rd_en", a_rd_en, 0);
      check_eq("mid_rst_rd_row", a_rd_row, 0);
      check_eq("mid_rst_rd_col", a_rd_col, 0);
      check_eq("mid_rst_valid", a_out_valid, 0);
      check_eq("mid_rst_data", a_out_data, 0);
      check_eq("mid_rst_out_row", a_out_row, 0);
      check_eq("mid_rst_out_col", a_out_col, 0);
      q_exp.delete();
      q_addr.delete();
      @(posedge clk); #2;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check_eq("no_done_after_rst", n_done - dn0, 0);
      check_eq("idle_after_rst", a_busy, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; out_ready = 1'b0; kernel_flat = '0;
      load_fixed();
      repeat (3) @(posedge clk);
      #2;
      check_eq("rst_busy", a_busy, 0);
      check_eq("rst_done", a_done, 0);
      check_eq("rst_rd_en", a_rd_en, 0);
      check_eq("rst_valid", a_out_valid, 0);
      check_eq("rst_data", a_out_data, 0);
      check_eq("rst_out_row", a_out_row, 0);
      rst = 1'b0;
      @(posedge clk); #2;

      run_conv(0, 1'b0);
      check_eq("relu_0_0", res_relu[0][0], 0);
      check_eq("relu_0_1", res_relu[0][1], 20);
      check_eq("relu_1_0", res_relu[1][0], 0);
      check_eq("relu_1_1", res_relu[1][1], 0);
      check_eq("relu_2_1", res_relu[2][1], 12);
      check_eq("none_0_0", res_none[0][0], -78);
      check_eq("none_2_0", res_none[2][0], -98);
      check_eq("none_1_1", res_none[1][1], -6);

      run_conv(2, 1'b0);
      check_eq("bp_relu_0_1", res_relu[0][1], 20);
      run_conv(1, 1'b1);
      run_conv(0, 1'b1);

      reset_mid_run();
      run_conv(0, 1'b0);
      check_eq("replay_relu_2_1", res_relu[2][1], 12);

      for (int it = 0; it < 4; it++) begin
         load_random();
         run_conv(it % 3, 1'(it & 1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: still running at t=%0t, expected to finish before t=500000", $time);
      $fatal(1);
   end

endmodule
